// File: rtl/alu_mdu_pipe.sv
// Registered, handshaked integer execute unit with iterative multiply and unsigned divide.
// Optional macro ALU_OVF_FLAG_EN adds a signed-overflow output for ADD/SUB.
module alu_mdu_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
`ifdef ALU_OVF_FLAG_EN
    output logic             overflow,
`endif
    output logic             ZERO
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110, OP_SRA  = 4'b0111, OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001, OP_MUL  = 4'b1010, OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100, OP_REMU = 4'b1101;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc, x, y;
    logic [CNT_W-1:0] cnt;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic zero_of(input logic [3:0] op, input logic [WIDTH-1:0] r);
        return (op == OP_SLT || op == OP_SLTU) ? r[0] : (r == '0);
    endfunction

    logic [WIDTH-1:0] alu_res;
    logic             ovf_res;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] sum, diff;

    assign sh   = b[SH_W-1:0];
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        ovf_res = 1'b0;
        case (ALUOp)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res = sum;
                ovf_res = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SUB: begin
                alu_res = diff;
                ovf_res = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> sh);
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_NOR:  alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

    // Iteration datapath: MUL uses acc=product, x=multiplicand, y=multiplier;
    // DIVU/REMU use acc=remainder, x=dividend shifting into quotient, y=divisor.
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] acc_mul, x_mul, y_mul, acc_div, x_div, fin;
    logic             div0, last;

    assign trial   = {acc, x[WIDTH-1]};
    assign ge      = trial >= {1'b0, y};
    assign acc_mul = acc + (y[0] ? x : '0);
    assign x_mul   = x << 1;
    assign y_mul   = y >> 1;
    assign acc_div = ge ? (trial[WIDTH-1:0] - y) : trial[WIDTH-1:0];
    assign x_div   = {x[WIDTH-2:0], ge};
    assign div0    = (op_q != OP_MUL) && (y == '0);
    assign last    = div0 || (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        fin = acc_mul;
        if (op_q == OP_DIVU)      fin = div0 ? '1 : x_div;
        else if (op_q == OP_REMU) fin = div0 ? x : acc_div;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = is_multi(ALUOp) ? BUSY : DONE;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            Result <= '0;
            ZERO   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            op_q   <= '0;
`ifdef ALU_OVF_FLAG_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= ALUOp;
                    if (is_multi(ALUOp)) begin
                        acc <= '0;
                        x   <= a;
                        y   <= b;
                        cnt <= '0;
                    end else begin
                        Result <= alu_res;
                        ZERO   <= zero_of(ALUOp, alu_res);
`ifdef ALU_OVF_FLAG_EN
                        overflow <= ovf_res;
`endif
                    end
                end
                BUSY: begin
                    if (last) begin
                        Result <= fin;
                        ZERO   <= zero_of(op_q, fin);
`ifdef ALU_OVF_FLAG_EN
                        overflow <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (op_q == OP_MUL) begin
                            acc <= acc_mul;
                            x   <= x_mul;
                            y   <= y_mul;
                        end else begin
                            acc <= acc_div;
                            x   <= x_div;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef ALU_OVF_FLAG_EN
    logic unused_ovf;
    assign unused_ovf = ovf_res;
`endif
endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Directed bench for alu_mdu_pipe: 64-bit instance for the main function, 8-bit instance for narrow width.
module tb_alu_mdu_pipe;
  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [63:0] a, b, result;
  logic [3:0]  aluop;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  aluop8;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf, ovf8;
`endif

  int tests = 0;
  int fails = 0;

  alu_mdu_pipe #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUOp(aluop), .out_valid(out_valid), .out_ready(out_ready),
    .Result(result),
`ifdef ALU_OVF_FLAG_EN
    .overflow(ovf),
`endif
    .ZERO(zero)
  );

  alu_mdu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ALUOp(aluop8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Result(result8),
`ifdef ALU_OVF_FLAG_EN
    .overflow(ovf8),
`endif
    .ZERO(zero8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] er, input logic ez,
                        input int el, input bit toggle);
    int lat;
    check({tag, " in_ready"}, in_ready, 1);
    a = x; b = y; aluop = op; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (toggle) begin
        in_valid = lat[0]; aluop = 4'b0010; a = 64'd1; b = 64'd1;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 0;
    check({tag, " latency"}, lat, el);
    check({tag, " result"}, result, er);
    check({tag, " zero"}, zero, ez);
    @(posedge clk); #1;
    check({tag, " back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run_op8(input string tag, input logic [3:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] er, input logic eo,
                         input int el);
    int lat;
    a8 = x; b8 = y; aluop8 = op; in_valid8 = 1;
    @(posedge clk); #1;
    in_valid8 = 0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, el);
    check({tag, " result"}, result8, er);
`ifdef ALU_OVF_FLAG_EN
    check({tag, " overflow"}, ovf8, eo);
`else
    if (eo) ; // overflow expectation only meaningful with the flag port present
`endif
    @(posedge clk); #1;
    check({tag, " back_idle"}, in_ready8, 1);
  endtask

  initial begin
    reset = 0;
    in_valid = 0; out_ready = 1; a = 0; b = 0; aluop = 0;
    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; aluop8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 0);
    check("reset zero", zero, 0);
    check("reset flags", {in_ready, out_valid}, 2'b10);
    reset = 1;
    @(posedge clk); #1;

    run_op("add",    4'b0010, 64'd5, 64'd7, 64'd12, 0, 1, 0);
    run_op("sub",    4'b0110, 64'd9, 64'd9, 64'd0, 1, 1, 0);
    run_op("slt",    4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1, 1, 0);
    run_op("sltu",   4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1, 0);
    run_op("and",    4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 0, 1, 0);
    run_op("or",     4'b0001, 64'hF0F0, 64'hFF00, 64'hFFF0, 0, 1, 0);
    run_op("xor",    4'b0011, 64'hF0F0, 64'hFF00, 64'h0FF0, 0, 1, 0);
    run_op("sll",    4'b0100, 64'd1, 64'h43, 64'd8, 0, 1, 0);
    run_op("srl",    4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 0, 1, 0);
    run_op("sra",    4'b0111, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 0, 1, 0);
    run_op("nor",    4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    run_op("undef",  4'b1110, 64'd3, 64'd3, 64'd0, 1, 1, 0);
    run_op("addwrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 1, 0);
    run_op("mul",    4'b1010, 64'hFFFF_FFFF, 64'h1_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0, 65, 1);
    run_op("mulwrap", 4'b1010, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1, 65, 0);
    run_op("divu",   4'b1011, 64'd100, 64'd7, 64'd14, 0, 65, 0);
    run_op("remu",   4'b1101, 64'd100, 64'd7, 64'd2, 0, 65, 0);
    run_op("divu0",  4'b1011, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 0);
    run_op("remu0",  4'b1101, 64'd100, 64'd0, 64'd100, 0, 2, 0);

    // Result held in DONE while the consumer stalls; a new request must be ignored.
    out_ready = 0;
    a = 64'd3; b = 64'd4; aluop = 4'b0010; in_valid = 1;
    @(posedge clk); #1;
    aluop = 4'b0110;
    check("hold first", {out_valid, result}, {1'b1, 64'd7});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold stable", {out_valid, in_ready, result}, {2'b10, 64'd7});
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check("hold release", {in_ready, out_valid}, 2'b10);

    // Reset in the middle of a multiply.
    a = 64'd12345; b = 64'd678; aluop = 4'b1010; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_mul busy", {in_ready, out_valid}, 2'b00);
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    check("mid_mul flags", {in_ready, out_valid}, 2'b10);
    check("mid_mul result", result, 0);
    check("mid_mul zero", zero, 0);
    run_op("post_reset", 4'b0010, 64'd1, 64'd2, 64'd3, 0, 1, 0);

    run_op8("w8 add",  4'b0010, 8'h7F, 8'h01, 8'h80, 1, 1);
    run_op8("w8 sub",  4'b0110, 8'h80, 8'h01, 8'h7F, 1, 1);
    run_op8("w8 sra",  4'b0111, 8'h80, 8'h03, 8'hF0, 0, 1);
    run_op8("w8 mul",  4'b1010, 8'd3, 8'd5, 8'd15, 0, 9);
    run_op8("w8 divu", 4'b1011, 8'd200, 8'd9, 8'd22, 0, 9);
    run_op8("w8 remu", 4'b1101, 8'd200, 8'd9, 8'd2, 0, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_mdu_pipe.md
Name: alu_mdu_pipe

Overview:
- Parametrised-width integer execute unit for the RISC-V datapath.
- Supersedes the combinational 64-bit ALU with a registered, handshaked unit.
- Adds XOR, shifts, signed and unsigned compare, an iterative multiplier and an iterative unsigned divider.
- Sits in EX; the hazard unit stalls the pipe while `in_ready` is low.

Parameters:
- WIDTH, 64, operand and result width in bits (legal values: 8–64, power of two).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ALUOp  input  4  operation select.
- out_valid  output  1  Result/ZERO valid.
- out_ready  input  1  consumer accepts the result.
- Result  output  WIDTH  registered result.
- ZERO  output  1  branch flag.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; Result=0; ZERO=0; out_valid=0; counter=0.
  - Reset aborts any in-progress mul/div; partial state is discarded.
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011.
  - SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - SLTU 1000, SLT 1001, MUL 1010, DIVU 1011.
  - NOR 1100, REMU 1101.
  - Unlisted codes: Result=0.
- Arithmetic rules:
  - ADD/SUB/MUL wrap modulo 2^WIDTH; MUL returns the low WIDTH bits.
  - Shift amount = b[$clog2(WIDTH)-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
  - Divide by zero: DIVU returns all-ones; REMU returns a.
- ZERO flag:
  - For SLT/SLTU: ZERO = Result[0] (branch-taken flag).
  - Otherwise: ZERO = (Result==0).
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state==IDLE).
  - Request is accepted when in_valid && in_ready; a, b and ALUOp are captured in that cycle.
  - IDLE, accept, single-cycle op: Result/ZERO registered at the same edge; next state DONE.
  - IDLE, accept, MUL/DIVU/REMU: load working registers, counter=0; next state BUSY.
  - BUSY: one iteration per cycle.
    - MUL: shift-add, LSB-first.
    - DIVU/REMU: restoring, MSB-first.
    - After WIDTH iterations, latch Result/ZERO; next state DONE.
  - Divide by zero skips iterations: BUSY lasts one cycle.
  - DONE: out_valid=1; Result/ZERO held stable until out_ready=1, then IDLE on the next edge.
  - DONE with out_ready low: hold indefinitely; no new request is accepted.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
  - Divide by zero: 2 cycles.
- Throughput: one op per 2 cycles minimum (IDLE/DONE alternate); no back-to-back issue.
- in_valid while busy: ignored; the requester holds it, and the value is sampled only when in_ready=1.
- Operand changes while in BUSY/DONE have no effect.
- Result and ZERO retain their last value in IDLE; out_valid=0.

Optional Feature:
- Macro: ALU_OVF_FLAG_EN.
- When defined:
  - Adds output port `overflow` (1 bit), registered with Result.
  - ADD: overflow = a[W-1]==b[W-1] && Result[W-1]!=a[W-1].
  - SUB: overflow = a[W-1]!=b[W-1] && Result[W-1]!=a[W-1].
  - Other ops: overflow = 0.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=64 unless stated):
- Reset then ADD a=5, b=7, out_ready=1: out_valid rises 1 cycle after accept; Result=12, ZERO=0; in_ready returns high the following cycle.
- SUB a=9, b=9: Result=0, ZERO=1. SLT a=-1, b=1: Result=1, ZERO=1. SLTU with the same operands: Result=0, ZERO=0.
- MUL a=0xFFFF_FFFF, b=0x1_0000_0001: out_valid exactly 65 cycles after accept; Result=0xFFFF_FFFF_FFFF_FFFF. Toggling in_valid during BUSY is ignored.
- DIVU a=100, b=7 gives Result=14; REMU gives 2. DIVU a=100, b=0 gives all-ones after 2 cycles; REMU a=100, b=0 gives 100.
- Hold out_ready=0 in DONE for 10 cycles: Result stable, in_ready=0. Assert reset in the middle of a MUL at iteration 30: next cycle IDLE, out_valid=0, Result=0.
- WIDTH=8 with ALU_OVF_FLAG_EN: ADD 0x7F+0x01 gives 0x80, overflow=1. SRA 0x80 by 3 gives 0xF0. MUL latency 9.
